// File: rtl/z_serial_adder_ctrl.sv
// Bit-serial add sequencer feeding one external full-adder slice, LSB first; optional ovf port under Z_SERIAL_OVF_EN.
// Latency: result and done WIDTH+1 cycles after accepted start; no backpressure, start outside IDLE is dropped.
module z_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_init,
  output logic             fa_gen,
  output logic             fa_prop,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef Z_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;
  logic             in_run, last_bit;

  assign in_run   = (state_q == RUN);
  assign last_bit = in_run && (bit_cnt == LAST_BIT);
  assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};

  // Slice inputs are forced quiet outside RUN so it only toggles while adding.
  assign fa_gen  = in_run & a_sh[0] & b_sh[0];
  assign fa_prop = in_run & (a_sh[0] ^ b_sh[0]);
  assign fa_cin  = in_run & carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= c_init;
      sum_sh  <= '0;
      bit_cnt <= '0;
    end else if (in_run) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh  <= sum_next;
      carry_q <= fa_cout;
      if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The final bit's sum and carry arrive on the same edge that commits the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else if (last_bit) begin
      result    <= sum_next;
      carry_out <= fa_cout;
    end
  end

`ifdef Z_SERIAL_OVF_EN
  // fa_cin during the MSB is the carry into the sign bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (last_bit) ovf <= fa_cin ^ fa_cout;
  end
`endif

endmodule

// File: tb/tb_z_serial_adder_ctrl.sv
// Directed and random bench for z_serial_adder_ctrl with a behavioural full-adder slice.
module tb_z_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             c_init;
  logic             fa_gen, fa_prop, fa_cin, fa_sum, fa_cout;
  logic             busy, done, carry_out;
  logic [WIDTH-1:0] result;
`ifdef Z_SERIAL_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External slice: sum and carry from generate/propagate.
  assign #2 fa_sum  = fa_prop ^ fa_cin;
  assign #2 fa_cout = fa_gen | (fa_prop & fa_cin);

  z_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_init(c_init),
    .fa_gen(fa_gen), .fa_prop(fa_prop), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .result(result),
`ifdef Z_SERIAL_OVF_EN
    .ovf(ovf),
`endif
    .carry_out(carry_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one add in the current IDLE cycle and check latency and result.
  task automatic run_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                         input logic [WIDTH-1:0] exp_r, input logic exp_c, input logic exp_o);
    int cnt;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; c_init = cv;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    cnt = 0;
    while (!done && cnt < WIDTH + 4) begin
      @(negedge clk);
      cnt++;
      if (!busy) check("fa_quiet", {30'd0, fa_gen, fa_prop}, 32'd0);
    end
    check("done_latency", 32'(cnt), 32'(WIDTH));
    check("result", 32'(result), 32'(exp_r));
    check("carry_out", 32'(carry_out), 32'(exp_c));
`ifdef Z_SERIAL_OVF_EN
    check("ovf", 32'(ovf), 32'(exp_o));
`else
    if (exp_o === 1'bx) $display("unused ovf expectation");
`endif
  endtask

  initial begin
    int dcnt;
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] ra, rb;
    logic rc, ro;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_init = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_fa", {29'd0, fa_gen, fa_prop, fa_cin}, 32'd0);
    rst = 1'b0;

    run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1);
    check("result_held", 32'(result), 32'h81);

    // Re-pulsed start during RUN cycle 3 must be dropped.
    @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h4A; c_init = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h00;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (done) begin
        dcnt++;
        check("ignored_start_result", 32'(result), 32'h7F);
      end
      @(negedge clk);
    end
    check("ignored_start_done_count", 32'(dcnt), 32'd1);

    // Reset at RUN bit 4 aborts the add.
    start = 1'b1; a = 8'hFF; b = 8'h01; c_init = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_carry", 32'(carry_out), 32'd0);
    check("mid_rst_fa", {29'd0, fa_gen, fa_prop, fa_cin}, 32'd0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("no_done_after_rst", 32'(dcnt), 32'd0);
    run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Back-to-back random adds at the earliest legal start.
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      ro = (ra[WIDTH-1] == rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
      run_add(ra, rb, rc, full[WIDTH-1:0], full[WIDTH], ro);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
